// File: rtl/rbfu_addr_gen_if.sv
// Issue-side bus of the RBFU read address generator: pass control in,
// per-bank addresses, lane selectors and issue tags out.
interface rbfu_addr_gen_if #(
    parameter int P      = 2,
    parameter int MAP    = 2,
    parameter int ADDR_W = 6
);
    logic                    start;
    logic                    en;
    logic [2*P*ADDR_W-1:0]   addr_bus;
    logic [2*P*MAP-1:0]      sel_BI_bus;
    logic                    rd_en;
    logic [2:0]              stage_idx;
    logic [5:0]              grp_idx;
    logic                    busy;
    logic                    done;

    // Controller side: launches passes and consumes the issue stream.
    modport master (
        output start, en,
        input  addr_bus, sel_BI_bus, rd_en, stage_idx, grp_idx, busy, done
    );

    // Generator side.
    modport slave (
        input  start, en,
        output addr_bus, sel_BI_bus, rd_en, stage_idx, grp_idx, busy, done
    );
endinterface

// File: rtl/rbfu_addr_gen.sv
// Read-side address / bank-routing generator for one forward NTT pass
// (N = 256, 4 banks, 2 radix-2 butterflies per cycle).
// Two register stages: the first captures the (stage, group) being issued
// and advances the counters, the second registers the bank addresses,
// lane selectors and issue tags together so they leave in the same cycle.
module rbfu_addr_gen #(
    parameter int P      = 2,
    parameter int MAP    = 2,
    parameter int LOGN   = 8,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    rbfu_addr_gen_if.slave   bus
);
    localparam int NB = 2 * P;
    localparam int SW = $clog2(LOGN);
    localparam int GW = LOGN - MAP;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg;
    logic [SW-1:0]         s_reg;
    logic [GW-1:0]         g_reg;
    logic                  all_issued_reg;
    logic                  iss_v_reg;
    logic [SW-1:0]         iss_s_reg;
    logic [GW-1:0]         iss_g_reg;
    logic [NB*ADDR_W-1:0]  addr_reg;
    logic [NB*MAP-1:0]     sel_reg;
    logic                  rd_en_reg;
    logic [SW-1:0]         stage_reg;
    logic [GW-1:0]         grp_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // Butterfly bit s, pair bit t = s+1 (wraps to 0 after the top bit).
    logic [SW-1:0]         t_pos;
    logic [LOGN-1:0]       g_ext;
    logic [LOGN-1:0]       bit_s;
    logic [LOGN-1:0]       bit_t;
    logic [LOGN-1:0]       base;
    logic [LOGN-1:0]       lane_c  [NB];
    logic [MAP-1:0]        lane_bi [NB];
    logic [NB*ADDR_W-1:0]  addr_next;
    logic [NB*MAP-1:0]     sel_next;

    assign t_pos = iss_s_reg + 1'b1;
    assign g_ext = LOGN'(iss_g_reg);
    assign bit_s = LOGN'(1) << iss_s_reg;
    assign bit_t = LOGN'(1) << t_pos;

    // Spread the group bits around the two zeroed positions. For s < 7 the
    // holes are adjacent (s, s+1); for s = 7 they are bit 0 and bit 7.
    assign base = (iss_s_reg == SW'(LOGN - 1))
                ? (g_ext << 1)
                : (((g_ext >> iss_s_reg) << ({1'b0, iss_s_reg} + 4'd2))
                   | (g_ext & (bit_s - LOGN'(1))));

    // Lane l sets bit s when l[0] and bit t when l[1]; its bank is the
    // base-4 digit sum of the coefficient index.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign lane_c[gi]  = base
                           | (((gi & 1) != 0) ? bit_s : '0)
                           | (((gi & 2) != 0) ? bit_t : '0);
        assign lane_bi[gi] = lane_c[gi][1:0] + lane_c[gi][3:2]
                           + lane_c[gi][5:4] + lane_c[gi][7:6];
    end

    // Scatter each lane's address and lane number into the bank it maps to.
    always_comb begin
        addr_next = '0;
        sel_next  = '0;
        for (int l = 0; l < NB; l++) begin
            addr_next[lane_bi[l]*ADDR_W +: ADDR_W] = lane_c[l][LOGN-1:MAP];
            sel_next[lane_bi[l]*MAP +: MAP]        = MAP'(l);
        end
    end

    // Pass FSM, stage/group counters, issue capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            s_reg          <= '0;
            g_reg          <= '0;
            all_issued_reg <= 1'b0;
            iss_v_reg      <= 1'b0;
            iss_s_reg      <= '0;
            iss_g_reg      <= '0;
            addr_reg       <= '0;
            sel_reg        <= '0;
            rd_en_reg      <= 1'b0;
            stage_reg      <= '0;
            grp_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            iss_v_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg      <= RUN;
                        s_reg          <= '0;
                        g_reg          <= '0;
                        all_issued_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.en && !all_issued_reg) begin
                        iss_v_reg <= 1'b1;
                        iss_s_reg <= s_reg;
                        iss_g_reg <= g_reg;
                        g_reg     <= g_reg + 1'b1;
                        if (g_reg == '1) begin
                            s_reg <= s_reg + 1'b1;
                            if (s_reg == '1) begin
                                all_issued_reg <= 1'b1;
                            end
                        end
                    end
                    // Leave once the final issue has been presented.
                    if (rd_en_reg && stage_reg == '1 && grp_reg == '1) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Output stage: update only on a real issue, otherwise hold.
            rd_en_reg <= iss_v_reg;
            if (iss_v_reg) begin
                addr_reg  <= addr_next;
                sel_reg   <= sel_next;
                stage_reg <= iss_s_reg;
                grp_reg   <= iss_g_reg;
            end
        end
    end

    assign bus.addr_bus   = addr_reg;
    assign bus.sel_BI_bus = sel_reg;
    assign bus.rd_en      = rd_en_reg;
    assign bus.stage_idx  = stage_reg;
    assign bus.grp_idx    = grp_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_rbfu_addr_gen.sv
// Self-checking bench for rbfu_addr_gen: a reference model derives each
// issue's coefficients directly from the stage/group rules and the
// digit-sum bank map; a scoreboard rebuilds coefficients from the outputs.
module tb_rbfu_addr_gen;
    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   cyc;
    int   cnt [4][256];

    rbfu_addr_gen_if bus ();

    rbfu_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected bank addresses / selectors for issue (s, g).
    function automatic void model_issue(input int s, input int g,
                                        output logic [23:0] a,
                                        output logic [7:0] sl);
        int t, base, k, c, b;
        t = (s + 1) % 8;
        base = 0;
        k = 0;
        a = '0;
        sl = '0;
        for (int p = 0; p < 8; p++) begin
            if (p != s && p != t) begin
                base = base | (((g >> k) & 1) << p);
                k++;
            end
        end
        for (int l = 0; l < 4; l++) begin
            c = base | (((l & 1) != 0) ? (1 << s) : 0) | (((l & 2) != 0) ? (1 << t) : 0);
            b = ((c & 3) + ((c >> 2) & 3) + ((c >> 4) & 3) + ((c >> 6) & 3)) % 4;
            a[b*6 +: 6] = 6'(c >> 2);
            sl[b*2 +: 2] = 2'(l);
        end
    endfunction

    // Rebuild the coefficient index held at address a of bank b.
    function automatic int coeff_of(input int b, input int a);
        int ds, low;
        ds = (a & 3) + ((a >> 2) & 3) + ((a >> 4) & 3);
        low = (((b - ds) % 4) + 4) % 4;
        return a * 4 + low;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.en = 1'b0;
        repeat (3) tick();
        checks++; if (bus.addr_bus !== 24'h0) $display("FAIL reset_addr: got %h expected 000000", bus.addr_bus); else passes++;
        checks++; if (bus.sel_BI_bus !== 8'h0) $display("FAIL reset_sel: got %h expected 00", bus.sel_BI_bus); else passes++;
        checks++; if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en); else passes++;
        checks++; if (bus.stage_idx !== 3'd0) $display("FAIL reset_stage: got %0d expected 0", bus.stage_idx); else passes++;
        checks++; if (bus.grp_idx !== 6'd0) $display("FAIL reset_grp: got %0d expected 0", bus.grp_idx); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passes++;
        rst = 1'b0;
        bus.en = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_no_start_busy: got %b expected 0", bus.busy); else passes++;
    endtask

    task automatic test_full_pass();
        int idx, done_cnt, done_at, start_cyc, bad;
        logic [23:0] ea;
        logic [7:0] es;
        logic [3:0] seen;
        for (int p = 0; p < 4; p++) for (int c = 0; c < 256; c++) cnt[p][c] = 0;
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        start_cyc = cyc;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) $display("FAIL busy_rise: got %b expected 1", bus.busy); else passes++;
        idx = 0;
        done_cnt = 0;
        done_at = -1;
        for (int n = 0; n < 600 && done_cnt == 0; n++) begin
            tick();
            if (bus.rd_en === 1'b1) begin
                model_issue(idx / 64, idx % 64, ea, es);
                checks++; if (bus.addr_bus !== ea) $display("FAIL pass_addr[%0d]: got %h expected %h", idx, bus.addr_bus, ea); else passes++;
                checks++; if (bus.sel_BI_bus !== es) $display("FAIL pass_sel[%0d]: got %h expected %h", idx, bus.sel_BI_bus, es); else passes++;
                checks++; if (bus.stage_idx !== 3'(idx / 64)) $display("FAIL pass_stage[%0d]: got %0d expected %0d", idx, bus.stage_idx, idx / 64); else passes++;
                checks++; if (bus.grp_idx !== 6'(idx % 64)) $display("FAIL pass_grp[%0d]: got %0d expected %0d", idx, bus.grp_idx, idx % 64); else passes++;
                if (idx == 0) begin
                    checks++; if (cyc - start_cyc != 2) $display("FAIL first_latency: got %0d expected 2", cyc - start_cyc); else passes++;
                    checks++; if (bus.addr_bus !== 24'h000000 || bus.sel_BI_bus !== 8'hE4) $display("FAIL issue_s0g0: got %h/%h expected 000000/e4", bus.addr_bus, bus.sel_BI_bus); else passes++;
                end
                if (idx == 1) begin
                    checks++; if (bus.addr_bus !== 24'h041041 || bus.sel_BI_bus !== 8'h93) $display("FAIL issue_s0g1: got %h/%h expected 041041/93", bus.addr_bus, bus.sel_BI_bus); else passes++;
                end
                if (idx == 65) begin
                    checks++; if (bus.addr_bus !== 24'h001001 || bus.sel_BI_bus !== 8'h63) $display("FAIL issue_s1g1: got %h/%h expected 001001/63", bus.addr_bus, bus.sel_BI_bus); else passes++;
                end
                if (idx == 448) begin
                    checks++; if (bus.addr_bus !== 24'h820000 || bus.sel_BI_bus !== 8'hD8) $display("FAIL issue_s7g0: got %h/%h expected 820000/d8", bus.addr_bus, bus.sel_BI_bus); else passes++;
                end
                seen = '0;
                for (int b = 0; b < 4; b++) seen[bus.sel_BI_bus[b*2 +: 2]] = 1'b1;
                checks++; if (seen !== 4'hF) $display("FAIL lanes_distinct[%0d]: got %b expected 1111", idx, seen); else passes++;
                for (int b = 0; b < 4; b++) cnt[int'(bus.stage_idx) / 2][coeff_of(b, int'(bus.addr_bus[b*6 +: 6]))]++;
                idx++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = cyc - start_cyc;
                checks++; if (bus.busy !== 1'b1) $display("FAIL busy_in_done: got %b expected 1", bus.busy); else passes++;
            end
        end
        checks++; if (idx != 512) $display("FAIL pass_issue_count: got %0d expected 512", idx); else passes++;
        checks++; if (done_at != 514) $display("FAIL done_cycle: got %0d expected 514", done_at); else passes++;
        // Start presented in the done cycle must not launch a pass.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b0) $display("FAIL done_single_pulse: got %b expected 0", bus.done); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL busy_fall: got %b expected 0", bus.busy); else passes++;
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) $display("FAIL start_on_done_ignored: got busy=%b rd_en=%b expected 0/0", bus.busy, bus.rd_en); else passes++;
        bad = 0;
        for (int p = 0; p < 4; p++) for (int c = 0; c < 256; c++) if (cnt[p][c] != 2) bad++;
        checks++; if (bad != 0) $display("FAIL coeff_coverage: got %0d bad entries expected 0", bad); else passes++;
    endtask

    task automatic test_stall();
        int idx, gaps, start_cyc, left, done_at;
        bit stalled;
        logic [23:0] ea, last_a;
        logic [7:0] es, last_s;
        logic [2:0] last_st;
        logic [5:0] last_g;
        last_a = '0; last_s = '0; last_st = '0; last_g = '0;
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        start_cyc = cyc;
        bus.start = 1'b0;
        idx = 0; gaps = 0; left = 0; stalled = 1'b0; done_at = -1;
        for (int n = 0; n < 700 && done_at < 0; n++) begin
            tick();
            bus.start = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) bus.en = 1'b1;
            end
            if (bus.rd_en === 1'b1) begin
                model_issue(idx / 64, idx % 64, ea, es);
                checks++; if (bus.addr_bus !== ea) $display("FAIL stall_addr[%0d]: got %h expected %h", idx, bus.addr_bus, ea); else passes++;
                checks++; if (bus.sel_BI_bus !== es) $display("FAIL stall_sel[%0d]: got %h expected %h", idx, bus.sel_BI_bus, es); else passes++;
                checks++; if (bus.stage_idx !== 3'(idx / 64) || bus.grp_idx !== 6'(idx % 64)) $display("FAIL stall_seq[%0d]: got s%0d g%0d expected s%0d g%0d", idx, bus.stage_idx, bus.grp_idx, idx / 64, idx % 64); else passes++;
                last_a = bus.addr_bus; last_s = bus.sel_BI_bus; last_st = bus.stage_idx; last_g = bus.grp_idx;
                idx++;
                if (idx == 11 && !stalled) begin
                    bus.en = 1'b0;
                    left = 3;
                    stalled = 1'b1;
                end
                if (idx == 100) bus.start = 1'b1;
            end else if (idx > 0 && idx < 512) begin
                gaps++;
                checks++; if (bus.addr_bus !== last_a || bus.sel_BI_bus !== last_s) $display("FAIL stall_hold_bus: got %h/%h expected %h/%h", bus.addr_bus, bus.sel_BI_bus, last_a, last_s); else passes++;
                checks++; if (bus.stage_idx !== last_st || bus.grp_idx !== last_g) $display("FAIL stall_hold_idx: got s%0d g%0d expected s%0d g%0d", bus.stage_idx, bus.grp_idx, last_st, last_g); else passes++;
            end
            if (bus.done === 1'b1) done_at = cyc - start_cyc;
        end
        checks++; if (gaps != 3) $display("FAIL stall_gap_cycles: got %0d expected 3", gaps); else passes++;
        checks++; if (idx != 512) $display("FAIL stall_issue_count: got %0d expected 512", idx); else passes++;
        checks++; if (done_at != 517) $display("FAIL stall_done_cycle: got %0d expected 517", done_at); else passes++;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_pass();
        bit found;
        bus.en = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick();
            if (bus.rd_en === 1'b1 && bus.stage_idx === 3'd3 && bus.grp_idx === 6'd20) found = 1'b1;
        end
        checks++; if (found !== 1'b1) $display("FAIL reach_s3g20: got %b expected 1", found); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.addr_bus !== 24'h0 || bus.sel_BI_bus !== 8'h0) $display("FAIL midrst_bus: got %h/%h expected 000000/00", bus.addr_bus, bus.sel_BI_bus); else passes++;
        checks++; if (bus.rd_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL midrst_ctrl: got rd_en=%b done=%b busy=%b expected 0/0/0", bus.rd_en, bus.done, bus.busy); else passes++;
        checks++; if (bus.stage_idx !== 3'd0 || bus.grp_idx !== 6'd0) $display("FAIL midrst_idx: got s%0d g%0d expected s0 g0", bus.stage_idx, bus.grp_idx); else passes++;
        repeat (2) tick();
        checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) $display("FAIL midrst_idle: got busy=%b rd_en=%b expected 0/0", bus.busy, bus.rd_en); else passes++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        checks++; if (bus.rd_en !== 1'b1 || bus.stage_idx !== 3'd0 || bus.grp_idx !== 6'd0) $display("FAIL restart_first: got rd_en=%b s%0d g%0d expected 1 s0 g0", bus.rd_en, bus.stage_idx, bus.grp_idx); else passes++;
        checks++; if (bus.addr_bus !== 24'h000000 || bus.sel_BI_bus !== 8'hE4) $display("FAIL restart_bus: got %h/%h expected 000000/e4", bus.addr_bus, bus.sel_BI_bus); else passes++;
        tick();
        checks++; if (bus.grp_idx !== 6'd1 || bus.sel_BI_bus !== 8'h93) $display("FAIL restart_second: got g%0d sel %h expected g1 sel 93", bus.grp_idx, bus.sel_BI_bus); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cyc = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.en = 1'b0;
        test_reset();
        test_full_pass();
        test_stall();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
